// File: rtl/logit_vote_classifier_if.sv
// Logit-in / decision-out handshake bundle
// for the vote classifier.
interface logit_vote_classifier_if #(
  parameter int OUTPUT_SIZE = 3,
  parameter int DATA_WIDTH  = 16,
  parameter int VOTE_WINDOW = 4,
  parameter int ACC_WIDTH   = 24,
  parameter int CLS_WIDTH   = 2
);
  localparam int VCW = $clog2(VOTE_WINDOW) + 1;

  logic                              i_valid;
  logic                              i_ready;
  logic [OUTPUT_SIZE*DATA_WIDTH-1:0] i_logits;
  logic                              i_clear;
  logic                              o_valid;
  logic                              o_ready;
  logic [CLS_WIDTH-1:0]              o_class;
  logic [VCW-1:0]                    o_votes;
  logic signed [ACC_WIDTH:0]         o_margin;

  modport master (
    output i_valid, i_logits, i_clear, o_ready,
    input  i_ready, o_valid, o_class, o_votes, o_margin
  );

  modport slave (
    input  i_valid, i_logits, i_clear, o_ready,
    output i_ready, o_valid, o_class, o_votes, o_margin
  );
endinterface

// File: rtl/logit_vote_classifier.sv
// Windowed argmax voter: one class per cycle,
// emits class, vote count and sum margin.
module logit_vote_classifier #(
  parameter int OUTPUT_SIZE = 3,
  parameter int DATA_WIDTH  = 16,
  parameter int VOTE_WINDOW = 4,
  parameter int ACC_WIDTH   = 24,
  parameter int CLS_WIDTH   = 2
) (
  input logic clk,
  input logic rst_n,
  logit_vote_classifier_if.slave bus
);
  localparam int VCW = $clog2(VOTE_WINDOW) + 1;
  localparam logic [CLS_WIDTH-1:0] LAST_IDX =
    CLS_WIDTH'(OUTPUT_SIZE - 1);
  localparam logic [VCW-1:0] WIN_N = VCW'(VOTE_WINDOW);

  typedef enum logic [2:0] {
    IDLE, SCAN, UPDATE, DECIDE, MARGIN, DONE
  } state_t;

  state_t state, state_nx;

  logic signed [DATA_WIDTH-1:0] lg    [OUTPUT_SIZE];
  logic signed [ACC_WIDTH-1:0]  sum   [OUTPUT_SIZE];
  logic [VCW-1:0]               votes [OUTPUT_SIZE];
  logic [VCW-1:0]               cnt;
  logic [CLS_WIDTH-1:0]         idx;
  logic [CLS_WIDTH-1:0]         best;
  logic [CLS_WIDTH-1:0]         win;
  logic signed [ACC_WIDTH-1:0]  max_o;
  logic                         max_ok;

  logic                         o_valid_q;
  logic [CLS_WIDTH-1:0]         o_class_q;
  logic [VCW-1:0]               o_votes_q;
  logic signed [ACC_WIDTH:0]    o_margin_q;

  logic                         accept;
  logic                         last;
  logic                         beat;
  logic                         take_max;
  logic signed [ACC_WIDTH-1:0]  max_nx;
  logic signed [ACC_WIDTH:0]    margin;

  assign bus.i_ready  = (state == IDLE) && !bus.i_clear;
  assign accept       = bus.i_valid && bus.i_ready;
  assign last         = idx == LAST_IDX;
  assign bus.o_valid  = o_valid_q;
  assign bus.o_class  = o_class_q;
  assign bus.o_votes  = o_votes_q;
  assign bus.o_margin = o_margin_q;

  // Per-class compare terms for the serial winner and margin scans
  always_comb begin
    beat = (votes[idx] > votes[win]) ||
           ((votes[idx] == votes[win]) &&
            (sum[idx] > sum[win]));
    take_max = (idx != win) &&
               (!max_ok || (sum[idx] > max_o));
    max_nx = take_max ? sum[idx] : max_o;
    margin = (ACC_WIDTH+1)'(sum[win]) -
             (ACC_WIDTH+1)'(max_nx);
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state decode
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:   if (accept) state_nx = SCAN;
      SCAN:   if (last) state_nx = UPDATE;
      UPDATE: state_nx = ((cnt + 1'b1) == WIN_N) ?
                         DECIDE : IDLE;
      DECIDE: if (last) state_nx = MARGIN;
      MARGIN: if (last) state_nx = DONE;
      DONE:   if (bus.o_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Window accumulators, serial scans and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < OUTPUT_SIZE; k++) begin
        lg[k]    <= '0;
        sum[k]   <= '0;
        votes[k] <= '0;
      end
      cnt        <= '0;
      idx        <= '0;
      best       <= '0;
      win        <= '0;
      max_o      <= '0;
      max_ok     <= 1'b0;
      o_valid_q  <= 1'b0;
      o_class_q  <= '0;
      o_votes_q  <= '0;
      o_margin_q <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          idx <= '0;
          if (bus.i_clear) begin
            for (int k = 0; k < OUTPUT_SIZE; k++) begin
              sum[k]   <= '0;
              votes[k] <= '0;
            end
            cnt <= '0;
          end else if (accept) begin
            for (int k = 0; k < OUTPUT_SIZE; k++)
              lg[k] <= bus.i_logits[k*DATA_WIDTH +: DATA_WIDTH];
          end
        end
        SCAN: begin
          sum[idx] <= sum[idx] + ACC_WIDTH'(lg[idx]);
          if (idx == '0)
            best <= '0;
          else if (lg[idx] > lg[best])
            best <= idx;
          idx <= last ? '0 : idx + 1'b1;
        end
        UPDATE: begin
          votes[best] <= votes[best] + 1'b1;
          cnt         <= cnt + 1'b1;
          idx         <= '0;
        end
        DECIDE: begin
          if (idx == '0)
            win <= '0;
          else if (beat)
            win <= idx;
          if (last) max_ok <= 1'b0;
          idx <= last ? '0 : idx + 1'b1;
        end
        MARGIN: begin
          max_o <= max_nx;
          if (take_max) max_ok <= 1'b1;
          if (last) begin
            o_valid_q  <= 1'b1;
            o_class_q  <= win;
            o_votes_q  <= votes[win];
            o_margin_q <= margin;
          end
          idx <= last ? '0 : idx + 1'b1;
        end
        DONE: begin
          idx <= '0;
          if (bus.o_ready) begin
            o_valid_q <= 1'b0;
            for (int k = 0; k < OUTPUT_SIZE; k++) begin
              sum[k]   <= '0;
              votes[k] <= '0;
            end
            cnt <= '0;
          end
        end
        default: idx <= '0;
      endcase
    end
  end
endmodule

// File: tb/tb_logit_vote_classifier.sv
// Randomized + directed bench for the vote
// classifier against a window-level model.
module tb_logit_vote_classifier;
  localparam int NC = 3;
  localparam int DW = 16;
  localparam int VW = 4;
  localparam int AW = 24;
  localparam int CW = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logit_vote_classifier_if #(
    .OUTPUT_SIZE(NC), .DATA_WIDTH(DW),
    .VOTE_WINDOW(VW), .ACC_WIDTH(AW),
    .CLS_WIDTH(CW)
  ) bus ();

  logit_vote_classifier #(
    .OUTPUT_SIZE(NC), .DATA_WIDTH(DW),
    .VOTE_WINDOW(VW), .ACC_WIDTH(AW),
    .CLS_WIDTH(CW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  int     mv [NC];
  longint ms [NC];
  int     mcnt;
  int     e_cls;
  int     e_votes;
  longint e_margin;
  bit     pending;

  task automatic check(input string tag,
                       input longint obs,
                       input longint exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d",
               tag, obs, exp);
    end
  endtask

  task automatic m_clear();
    for (int k = 0; k < NC; k++) begin
      mv[k] = 0;
      ms[k] = 0;
    end
    mcnt = 0;
  endtask

  function automatic int rnd_logit(input int mode);
    int r;
    case (mode)
      0: r = int'($signed(16'($urandom)));
      1: r = int'($urandom_range(0, 4)) - 2;
      default: begin
        case ($urandom_range(0, 2))
          0: r = -32768;
          1: r = -32767;
          default: r = 32767;
        endcase
      end
    endcase
    return r;
  endfunction

  // window decision from the accumulated votes/sums
  task automatic m_decide();
    int w;
    longint mo;
    bit have;
    w = 0;
    for (int k = 1; k < NC; k++)
      if (mv[k] > mv[w] ||
          (mv[k] == mv[w] && ms[k] > ms[w]))
        w = k;
    have = 0;
    mo = 0;
    for (int k = 0; k < NC; k++)
      if (k != w && (!have || ms[k] > mo)) begin
        mo = ms[k];
        have = 1;
      end
    e_cls = w;
    e_votes = mv[w];
    e_margin = ms[w] - mo;
    pending = 1;
  endtask

  task automatic send(input int l0, input int l1,
                      input int l2);
    int l [NC];
    logic [NC*DW-1:0] v;
    int lat;
    int b;
    bit fin;
    l = '{l0, l1, l2};
    for (int k = 0; k < NC; k++)
      v[k*DW +: DW] = DW'(l[k]);
    @(negedge clk);
    bus.i_valid = 1'b1;
    bus.i_logits = v;
    lat = 0;
    while (!bus.i_ready && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    if (!bus.i_ready) begin
      check("accept_timeout", 0, 1);
      bus.i_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 bus.i_valid = 1'b0;
    b = 0;
    for (int k = 1; k < NC; k++)
      if (l[k] > l[b]) b = k;
    mv[b]++;
    for (int k = 0; k < NC; k++)
      ms[k] += l[k];
    mcnt++;
    fin = (mcnt == VW);
    lat = 1;
    while (lat < 100) begin
      @(negedge clk);
      if (bus.o_valid || bus.i_ready) break;
      @(posedge clk);
      lat++;
    end
    if (fin) begin
      check("lat_final", lat, 3*NC + 2);
      check("final_valid", bus.o_valid, 1);
      m_decide();
    end else begin
      check("lat_sample", lat, NC + 2);
      check("sample_ready", bus.i_ready, 1);
    end
  endtask

  task automatic take(input int hold);
    int t;
    t = 0;
    while (!bus.o_valid && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("o_valid", bus.o_valid, 1);
    check("o_class", bus.o_class, e_cls);
    check("o_votes", bus.o_votes, e_votes);
    check("o_margin", bus.o_margin, e_margin);
    bus.i_valid = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("bp_ready", bus.i_ready, 0);
      check("bp_valid", bus.o_valid, 1);
      check("bp_class", bus.o_class, e_cls);
      check("bp_votes", bus.o_votes, e_votes);
      check("bp_margin", bus.o_margin, e_margin);
    end
    bus.i_valid = 1'b0;
    bus.o_ready = 1'b1;
    @(posedge clk);
    #1 bus.o_ready = 1'b0;
    @(negedge clk);
    check("hs_valid", bus.o_valid, 0);
    check("hs_ready", bus.i_ready, 1);
    pending = 0;
    m_clear();
  endtask

  task automatic clear_pulse();
    @(negedge clk);
    bus.i_clear = 1'b1;
    bus.i_valid = 1'b1;
    bus.i_logits = NC*DW'($urandom);
    #1 check("clr_ready", bus.i_ready, 0);
    @(posedge clk);
    #1;
    bus.i_clear = 1'b0;
    bus.i_valid = 1'b0;
    m_clear();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int wins;
    int mode;
    bus.i_valid = 1'b0;
    bus.i_logits = '0;
    bus.i_clear = 1'b0;
    bus.o_ready = 1'b0;
    pending = 0;
    m_clear();

    repeat (3) @(negedge clk);
    check("rst_valid", bus.o_valid, 0);
    check("rst_class", bus.o_class, 0);
    check("rst_votes", bus.o_votes, 0);
    check("rst_margin", bus.o_margin, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", bus.i_ready, 1);

    // reset in the middle of the 2nd sample's scan
    send(9, 1, 1);
    @(negedge clk);
    bus.i_valid = 1'b1;
    bus.i_logits = {16'd0, 16'd0, 16'd50};
    @(posedge clk);
    #1 bus.i_valid = 1'b0;
    @(negedge clk);
    check("mid_busy", bus.i_ready, 0);
    rst_n = 1'b0;
    #1;
    check("mid_valid", bus.o_valid, 0);
    check("mid_class", bus.o_class, 0);
    check("mid_votes", bus.o_votes, 0);
    check("mid_margin", bus.o_margin, 0);
    @(negedge clk);
    rst_n = 1'b1;
    m_clear();
    @(negedge clk);
    check("mid_ready", bus.i_ready, 1);

    // reference window
    send(10, 20, 5);
    send(30, -4, 0);
    send(1, 50, 2);
    send(7, 7, -3);
    check("win_cls_model", e_cls, 1);
    take(2);

    // full tie
    repeat (4) send(5, 5, 5);
    take(0);

    // negative extremes
    repeat (4) send(-32768, -32767, -32768);
    take(1);

    // long back-pressure
    repeat (4) send(-1, 2, 100);
    take(20);
    send(4, 4, 4);
    check("post_bp_cnt", mcnt, 1);

    // clear discards partial window
    m_clear();
    clear_pulse();
    send(0, 9, 0);
    send(0, 9, 0);
    clear_pulse();
    repeat (4) send(3, 1, 2);
    take(3);

    // randomized windows
    wins = 0;
    while (wins < 10) begin
      if ($urandom_range(0, 5) == 0) clear_pulse();
      mode = int'($urandom_range(0, 2));
      send(rnd_logit(mode), rnd_logit(mode),
           rnd_logit(mode));
      if (pending) begin
        take(int'($urandom_range(0, 5)));
        wins++;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/logit_vote_classifier.md
Name: logit_vote_classifier

Overview:
- Sits directly downstream of the output layer. Consumes its packed signed 16-bit logits through a valid/ready handshake.
- For each sample, finds the argmax class. It accumulates per-class votes and per-class logit sums over a window of VOTE_WINDOW samples.
- When the window is full, it emits one class decision, the winner's vote count, and a confidence margin.
- The final, sequential stage of the EEG classification pipeline. Comparisons run one class per cycle to keep area small.

Parameters:
- OUTPUT_SIZE, 3, number of classes (logits per sample); must be ≥ 2.
- DATA_WIDTH, 16, signed logit width.
- VOTE_WINDOW, 4, samples per decision; must be ≥ 1.
- ACC_WIDTH, 24, signed per-class sum width; must satisfy VOTE_WINDOW ≤ 2^(ACC_WIDTH-DATA_WIDTH), so no overflow is possible.
- CLS_WIDTH, 2, class index width; must be ≥ clog2(OUTPUT_SIZE).

Ports:
- clk  in  1  clock, all logic rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- i_valid  in  1  logits valid.
- i_ready  out  1  block can accept a sample.
- i_logits  in  OUTPUT_SIZE*DATA_WIDTH  signed logits; class k at bits [k*DATA_WIDTH +: DATA_WIDTH].
- i_clear  in  1  discard the partial window (acts only in IDLE).
- o_valid  out  1  decision valid.
- o_ready  in  1  consumer accepts the decision.
- o_class  out  CLS_WIDTH  decided class index.
- o_votes  out  clog2(VOTE_WINDOW)+1  number of votes won by o_class.
- o_margin  out  ACC_WIDTH+1  signed; sum[o_class] minus the max sum over the other classes.

Behaviour:

Reset:
- Clock is clk; reset is asynchronous, active-low rst_n.
- State returns to IDLE.
- All votes, sums and sample_cnt are cleared to 0.
- o_valid=0, o_class=0, o_votes=0, o_margin=0.
- Reset in any state discards the partial window and any pending decision.

Handshake:
- i_ready = (state==IDLE) && !i_clear.
- A sample is accepted on a rising edge with i_valid && i_ready. i_logits is latched into an internal register on that edge.
- The decision is delivered on the edge with o_valid && o_ready.
- o_class, o_votes and o_margin are registered and stay stable while o_valid is high.

i_clear:
- In IDLE, zeroes votes, sums and sample_cnt. It has priority over i_valid: no sample is accepted that cycle.
- Ignored in all other states.

FSM:
- IDLE: on accept, go to SCAN with idx=0.
- SCAN (OUTPUT_SIZE cycles): at idx, sum[idx] += logit[idx], sign-extended to ACC_WIDTH.
  - idx 0 initialises best=0.
  - For idx>0, best is updated only if logit[idx] > logit[best] (strict). A tie keeps the lower index.
- UPDATE (1 cycle): votes[best] += 1, sample_cnt += 1. If sample_cnt+1 == VOTE_WINDOW, go to DECIDE; else go to IDLE.
- DECIDE (OUTPUT_SIZE cycles): serial scan for the winner w. Class k replaces w if votes[k] > votes[w], or if votes are equal and sum[k] > sum[w]. Full tie keeps the lower index.
- MARGIN (OUTPUT_SIZE cycles): serial scan for max_other = max of sum[k] over k≠w.
  - Then o_margin = sum[w] − max_other, computed at ACC_WIDTH+1 bits, exact.
  - o_class=w and o_votes=votes[w] are registered.
- DONE: o_valid=1. On o_ready: clear votes, sums and sample_cnt, set o_valid=0, go to IDLE. o_ready outside DONE is ignored.

Latency:
- A non-final sample: i_ready is high again OUTPUT_SIZE+2 cycles after the accepting edge (5 with defaults).
- The final sample of a window: o_valid rises 3*OUTPUT_SIZE+2 edges after the accepting edge (11 with defaults).
- The next sample is accepted no earlier than the cycle after the o_ready handshake.

Boundaries:
- VOTE_WINDOW=1: every sample yields a decision; o_votes=1.
- Logits at −32768 are handled without overflow.
- Back-pressure in DONE can be held indefinitely; i_ready stays 0 throughout.

Test Plan:
- Reset: assert rst_n=0 mid-SCAN of the 2nd sample → outputs 0, i_ready=1 after release. A following full window decides as if fresh.
- Window (defaults):
  - Samples (10,20,5), (30,−4,0), (1,50,2), (7,7,−3) → per-sample argmax 1,0,1,0 (the 7/7 tie goes to 0).
  - Votes tie 2/2; sums 48/73/4 → o_class=1, o_votes=2, o_margin=25.
  - o_valid rises 11 cycles after the 4th accept.
- Full tie: four samples of (5,5,5) → o_class=0, o_votes=4, o_margin=0.
- Negative extremes: four samples of (−32768,−32767,−32768) → o_class=1, o_votes=4, o_margin=4.
- Back-pressure: hold o_ready=0 for 20 cycles in DONE with i_valid=1 → i_ready=0 and outputs stable throughout. On o_ready=1, one handshake occurs and the next sample is accepted in the following IDLE cycle.
- i_clear: accept 2 samples (0,9,0), then i_clear=1 with i_valid=1 in IDLE → no accept that cycle. Then 4 samples of (3,1,2) → o_class=0, o_votes=4, o_margin=4.
